// File: rtl/life_fb_writer.sv
// Queues life-engine cell results into a small FIFO and drains them to the
// framebuffer one write per cycle; also sweeps a full-screen clear on request.
module life_fb_writer #(
  parameter int CORDW        = 16,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 48,
  parameter int CIDXW        = 2,
  parameter int DEPTH        = 16,
  parameter int ONLY_CHANGED = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     alive,
  input  logic                     changed,
  input  logic signed [CORDW-1:0]  x,
  input  logic signed [CORDW-1:0]  y,
  input  logic                     clear_req,
  input  logic                     fb_busy,
  output logic                     fb_we,
  output logic signed [CORDW-1:0]  fbx,
  output logic signed [CORDW-1:0]  fby,
  output logic [CIDXW-1:0]         fb_cidx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     clear_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2*CORDW + CIDXW;

  typedef enum logic [1:0] {RUN, CLEAR, DONE} state_t;

  state_t           state;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CORDW-1:0] sx, sy;
  logic             queueable, full, push, pop, sweep_last;
  logic [EW-1:0]    rd_data;

  // A clear request takes priority: no push or pop happens in that cycle.
  always_comb begin
    queueable  = ready && (changed || (ONLY_CHANGED == 0));
    full       = (count == CW'(DEPTH));
    pop        = (state == RUN) && !clear_req && (count != '0) && !fb_busy;
    push       = (state == RUN) && !clear_req && queueable && (!full || pop);
    rd_data    = mem[rd_ptr];
    sweep_last = (sx == CORDW'(WIDTH-1)) && (sy == CORDW'(HEIGHT-1));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {x, y, CIDXW'(alive)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fb_we      <= 1'b0;
      fbx        <= '0;
      fby        <= '0;
      fb_cidx    <= '0;
      overflow   <= 1'b0;
      clear_done <= 1'b0;
      sx         <= '0;
      sy         <= '0;
    end else begin
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        RUN: begin
          if (clear_req) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            sx       <= '0;
            sy       <= '0;
            state    <= CLEAR;
          end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
              rd_ptr                  <= rd_ptr + 1'b1;
              fb_we                   <= 1'b1;
              {fbx, fby, fb_cidx}     <= rd_data;
            end
            case ({push, pop})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
            if (queueable && !push) overflow <= 1'b1;
          end
        end
        CLEAR: begin
          if (!fb_busy) begin
            fb_we   <= 1'b1;
            fbx     <= sx;
            fby     <= sy;
            fb_cidx <= '0;
            if (sweep_last) begin
              state      <= DONE;
              clear_done <= 1'b1;
            end else if (sx == CORDW'(WIDTH-1)) begin
              sx <= '0;
              sy <= sy + 1'b1;
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_life_fb_writer.sv
// Directed bench for life_fb_writer: per-cycle vector table plus sequences for
// filtering, overflow, full push/pop, clear sweep and reset mid-sweep.
module tb_life_fb_writer;

  logic               clk = 1'b0;
  logic               rst, ready, alive, changed, clear_req, fb_busy;
  logic signed [15:0] x, y;
  logic               fb_we, overflow, clear_done;
  logic signed [15:0] fbx, fby;
  logic [1:0]         fb_cidx;
  logic [4:0]         count;
  logic               a_fb_we, a_overflow, a_clear_done;
  logic signed [15:0] a_fbx, a_fby;
  logic [1:0]         a_fb_cidx;
  logic [4:0]         a_count;

  int total = 0;
  int bad   = 0;

  typedef struct { int x; int y; int c; } wr_t;
  wr_t qd[$];
  wr_t qa[$];

  typedef struct {
    logic rdy; logic ch; logic al; int x; int y; logic busy;
    logic ewe; int ex; int ey; int ec; int ecnt;
  } vec_t;
  vec_t vt[9];

  always #5 clk = ~clk;

  life_fb_writer #(.CORDW(16), .WIDTH(64), .HEIGHT(48), .CIDXW(2), .DEPTH(16),
                   .ONLY_CHANGED(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .alive(alive), .changed(changed),
    .x(x), .y(y), .clear_req(clear_req), .fb_busy(fb_busy),
    .fb_we(fb_we), .fbx(fbx), .fby(fby), .fb_cidx(fb_cidx),
    .count(count), .overflow(overflow), .clear_done(clear_done));

  life_fb_writer #(.CORDW(16), .WIDTH(64), .HEIGHT(48), .CIDXW(2), .DEPTH(16),
                   .ONLY_CHANGED(0)) dut_all (
    .clk(clk), .rst(rst), .ready(ready), .alive(alive), .changed(changed),
    .x(x), .y(y), .clear_req(clear_req), .fb_busy(fb_busy),
    .fb_we(a_fb_we), .fbx(a_fbx), .fby(a_fby), .fb_cidx(a_fb_cidx),
    .count(a_count), .overflow(a_overflow), .clear_done(a_clear_done));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (fb_we)   qd.push_back('{int'(fbx), int'(fby), int'(fb_cidx)});
    if (a_fb_we) qa.push_back('{int'(a_fbx), int'(a_fby), int'(a_fb_cidx)});
  endtask

  task automatic idle_inputs();
    ready = 1'b0; alive = 1'b0; changed = 1'b0; clear_req = 1'b0;
    fb_busy = 1'b0; x = '0; y = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    qd.delete();
    qa.delete();
  endtask

  task automatic push_cell(input int cx, input int cy, input logic al, input logic busy);
    ready = 1'b1; changed = 1'b1; alive = al; x = 16'(cx); y = 16'(cy); fb_busy = busy;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, int'(fb_we), 0);
    chk({tag, "_fbx"}, int'(fbx), 0);
    chk({tag, "_fby"}, int'(fby), 0);
    chk({tag, "_cidx"}, int'(fb_cidx), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_done"}, int'(clear_done), 0);
  endtask

  initial begin
    int  n_done;
    logic got_done;

    // Each row: inputs for one cycle, then outputs expected right after that edge.
    vt[0] = '{1'b1, 1'b1, 1'b1,  5,  7, 1'b0, 1'b0,  0,  0, 0, 1};
    vt[1] = '{1'b0, 1'b0, 1'b0,  0,  0, 1'b0, 1'b1,  5,  7, 1, 0};
    vt[2] = '{1'b0, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0,  0,  0, 0, 0};
    vt[3] = '{1'b1, 1'b0, 1'b1,  1,  1, 1'b0, 1'b0,  0,  0, 0, 0};
    vt[4] = '{1'b1, 1'b1, 1'b0, -3, 20, 1'b0, 1'b0,  0,  0, 0, 1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 63, 47, 1'b0, 1'b1, -3, 20, 0, 1};
    vt[6] = '{1'b0, 1'b0, 1'b0,  0,  0, 1'b1, 1'b0,  0,  0, 0, 1};
    vt[7] = '{1'b0, 1'b0, 1'b0,  0,  0, 1'b0, 1'b1, 63, 47, 1, 0};
    vt[8] = '{1'b0, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0,  0,  0, 0, 0};

    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst0");
    do_reset();

    for (int i = 0; i < 9; i++) begin
      ready = vt[i].rdy; changed = vt[i].ch; alive = vt[i].al;
      x = 16'(vt[i].x); y = 16'(vt[i].y); fb_busy = vt[i].busy;
      tick();
      chk($sformatf("vec%0d_we", i), int'(fb_we), int'(vt[i].ewe));
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].ecnt);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), 0);
      if (vt[i].ewe) begin
        chk($sformatf("vec%0d_fbx", i), int'(fbx), vt[i].ex);
        chk($sformatf("vec%0d_fby", i), int'(fby), vt[i].ey);
        chk($sformatf("vec%0d_cidx", i), int'(fb_cidx), vt[i].ec);
      end
    end

    // Unchanged cells: filtered by the default instance, all kept by dut_all.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ready = 1'b1; changed = 1'b0; alive = 1'(i % 2); x = 16'(i); y = 16'(2*i);
      tick();
      chk("filt_count", int'(count), 0);
    end
    idle_inputs();
    repeat (5) tick();
    chk("filt_writes", qd.size(), 0);
    chk("all_writes", qa.size(), 10);
    for (int i = 0; i < qa.size() && i < 10; i++) begin
      chk("all_x", qa[i].x, i);
      chk("all_y", qa[i].y, 2*i);
      chk("all_c", qa[i].c, i % 2);
    end

    // Overflow: 17 cells while the framebuffer is busy.
    do_reset();
    for (int i = 0; i < 17; i++) push_cell(i, 100 + i, 1'b1, 1'b1);
    idle_inputs();
    fb_busy = 1'b1;
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    fb_busy = 1'b0;
    repeat (25) tick();
    chk("ovf_writes", qd.size(), 16);
    for (int i = 0; i < qd.size() && i < 16; i++) begin
      chk("ovf_x", qd[i].x, i);
      chk("ovf_y", qd[i].y, 100 + i);
    end
    chk("ovf_drain_count", int'(count), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) push_cell(i, 0, 1'b0, 1'b1);
    chk("full_count", int'(count), 16);
    chk("full_ovf", int'(overflow), 0);
    push_cell(99, 9, 1'b1, 1'b0);
    chk("pp_count", int'(count), 16);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_we", int'(fb_we), 1);
    chk("pp_fbx", int'(fbx), 0);
    idle_inputs();
    repeat (25) tick();
    chk("pp_writes", qd.size(), 17);
    for (int i = 0; i < qd.size() && i < 17; i++)
      chk("pp_x", qd[i].x, (i == 16) ? 99 : i);

    // Clear sweep with random backpressure and ignored inputs.
    do_reset();
    for (int i = 0; i < 3; i++) push_cell(i, i, 1'b1, 1'b1);
    chk("clr_pre_count", int'(count), 3);
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_flush_count", int'(count), 0);
    chk("clr_flush_we", int'(fb_we), 0);
    got_done = 1'b0;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      fb_busy = 1'($urandom_range(0, 1));
      ready = 1'b1; changed = 1'b1; alive = 1'b1;
      x = 16'($urandom_range(0, 63)); y = 16'($urandom_range(0, 47));
      clear_req = ($urandom_range(0, 9) == 0);
      tick();
      if (clear_done) got_done = 1'b1;
    end
    idle_inputs();
    chk("clr_done_seen", int'(got_done), 1);
    chk("clr_writes_at_done", qd.size(), 3072);
    for (int i = 0; i < qd.size() && i < 3072; i++) begin
      chk("clr_x", qd[i].x, i % 64);
      chk("clr_y", qd[i].y, i / 64);
      chk("clr_c", qd[i].c, 0);
    end
    n_done = 0;
    repeat (10) begin
      tick();
      if (clear_done) n_done++;
    end
    chk("clr_extra_done", n_done, 0);
    chk("clr_writes_after", qd.size(), 3072);
    chk("clr_post_count", int'(count), 0);
    chk("clr_post_ovf", int'(overflow), 0);

    // Reset in the middle of a sweep.
    do_reset();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 500 && qd.size() < 100; c++) tick();
    chk("mid_reached", qd.size(), 100);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) tick();
    rst = 1'b0;
    qd.delete();
    repeat (50) tick();
    chk("mid_no_writes", qd.size(), 0);
    chk("mid_count", int'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
